image_window_ctrl: RTL
======================

# image_window_ctrl

Sequencer that scans the 28x28 image memory (784 words, 7-bit pixels, row-major) and streams the 3x3 convolution windows, stride 1, valid padding, to the downstream MAC. It sits between the image memory and the convolution datapath. It generates synchronous-read addresses, carries tap/window tags alongside the returned pixel, and honours valid/ready backpressure without losing reads. One scan covers 26x26 = 676 windows x 9 taps = 6084 pixel transfers.

## Interface
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 3, kernel side
- ADDR_W, 10, memory address width
- DATA_W, 7, pixel width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a scan; sampled only in IDLE
- busy  out  1  high from first cycle after accepted start until done
- done  out  1  one-cycle pulse after last transfer
- mem_en  out  1  read enable to image memory
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_en
- pix_valid  out  1  pix_* outputs hold a transfer
- pix_ready  in  1  consumer accepts; transfer when pix_valid && pix_ready
- pix_data  out  DATA_W  pixel value
- pix_tap  out  4  tap index 0..8, = ky*3+kx
- pix_first  out  1  pix_tap == 0
- pix_last  out  1  pix_tap == 8
- win_row  out  5  window top-left row 0..25
- win_col  out  5  window top-left column 0..25

## Operation
- Reset: every output is 0. The state is IDLE, all counters are 0, and the skid is empty.
- States:
  - IDLE -> SCAN on start.
  - SCAN -> DRAIN after the read for (row 25, col 25, tap 8) issues.
  - DRAIN -> DONE when the skid is empty, no read is in flight, and the final transfer occurs.
  - DONE -> IDLE unconditionally. done=1 for this single cycle.
- Counters nest kx (inner), ky, win_col, win_row (outer). kx and ky wrap 2->0. win_col wraps 25->0 with win_row+1.
- mem_addr = (win_row+ky)*IMG_W + (win_col+kx). It is computed from the issue counters at full ADDR_W; the maximum is 783.
- Issue: mem_en = SCAN && skid empty && !(pix_valid && !pix_ready). The counters advance only on an issuing cycle. mem_addr is don't-care when mem_en=0 but must not cause a read.
- Tags (tap, row, col) are registered with each issue and travel with the read.
- Return path: one cycle after issue, mem_rdata plus its tags load the output register if it is empty or being drained this cycle. Otherwise they load the one-entry skid.
- On a transfer with the skid full, the skid moves to the output register. No pixel is dropped or duplicated.
- start while busy, in DRAIN, or in DONE is ignored. busy=0 in IDLE and in DONE.
- rst asserted in any state returns to IDLE on the next edge, with all outputs 0. A scan aborted this way emits no done. A later start rescans from window (0,0).

## Timing
- start is high at edge t in IDLE. busy=1 and mem_en=1 (addr 0) in cycle t+1. pix_valid=1 with pixel[0] in cycle t+2.
- With pix_ready held at 1: one transfer per cycle, with no bubbles across kx, ky, column or row wraps. The last transfer is in cycle t+6085 and done=1 in cycle t+6086.
- While pix_valid && !pix_ready, all pix_* outputs hold stable and mem_en=0. After ready returns, at most one cycle of extra latency is added before issue resumes.
- A transfer and an issue may occur in the same cycle. A skid load and an output drain may also occur in the same cycle.

## Test plan
- Memory preloaded with addr mod 128; start, pix_ready=1 -> first 9 transfers have data/addr 0,1,2,28,29,30,56,57,58. Window (0,0) has tap 0..8, pix_first on tap 0 and pix_last on tap 8.
- Window boundary check: window (0,25) is followed by window (1,0) -> the first tap of (1,0) reads addr 28. The final transfer is (25,25) tap 8 at addr 783.
- Full scan with pix_ready=1 -> exactly 6084 transfers. done pulses in cycle t+6086 for 1 cycle, and busy falls in the same cycle.
- Random pix_ready (50%) -> the transfer sequence is identical to the ready=1 run. pix_* outputs are stable while stalled, and the mem_en=0 rule holds whenever stalled.
- rst pulsed in the middle of window (10,10) -> next cycle all outputs are 0 and no done appears. A new start gives a first transfer at addr 0.
- start pulsed during SCAN and in the DONE cycle -> ignored, with no counter disturbance. start in IDLE after done -> a clean second scan.

Source files
------------

// File: rtl/image_window_ctrl.sv
// rtl/image_window_ctrl.sv - 3x3 stride-1 window sequencer over a 28x28 image memory
//
// Scans every valid-padding 3x3 window of a row-major image and streams its
// nine pixels, tagged with tap index and window position, to the MAC.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a scan (sampled in IDLE only)
//   busy, done        scan in progress / one-cycle completion pulse
//   mem_en, mem_addr  synchronous-read request to the image memory
//   mem_rdata         read data, one cycle after mem_en
//   pix_valid/ready   output handshake
//   pix_data          pixel value
//   pix_tap           tap index ky*K+kx, pix_first/pix_last mark taps 0 and K*K-1
//   win_row, win_col  top-left corner of the window the pixel belongs to
module image_window_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [3:0]        pix_tap,
  output logic              pix_first,
  output logic              pix_last,
  output logic [4:0]        win_row,
  output logic [4:0]        win_col
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] LAST_K   = 2'(K - 1);
  localparam logic [4:0] LAST_COL = 5'(IMG_W - K);
  localparam logic [4:0] LAST_ROW = 5'(IMG_H - K);
  localparam logic [3:0] LAST_TAP = 4'(K * K - 1);

  logic [1:0] state;

  // issue-side counters: kx innermost, then ky, then window column, window row
  logic [1:0] kx, ky;
  logic [4:0] col, row;

  // output stage: live=1 means the pixel on pix_data is the memory's read
  // data this very cycle; on a stall it is captured into hold so the
  // outputs stay stable after the memory's data port moves on.
  logic              live;
  logic [DATA_W-1:0] hold;

  logic       stall, xfer, last_issue;
  logic [3:0] issue_tap;
  logic [ADDR_W-1:0] row_sum, col_sum;

  assign stall = pix_valid && !pix_ready;
  assign xfer  = pix_valid && pix_ready;

  // A read is issued only when the output slot is guaranteed free at the
  // same edge, so a returning pixel never needs to wait behind another one.
  assign mem_en = (state == S_SCAN) && !stall;

  assign row_sum  = ADDR_W'(row) + ADDR_W'(ky);
  assign col_sum  = ADDR_W'(col) + ADDR_W'(kx);
  assign mem_addr = row_sum * ADDR_W'(IMG_W) + col_sum;

  assign issue_tap  = 4'(ky) * 4'(K) + 4'(kx);
  assign last_issue = (kx == LAST_K) && (ky == LAST_K) &&
                      (col == LAST_COL) && (row == LAST_ROW);

  assign busy = (state == S_SCAN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  assign pix_data  = !pix_valid ? '0 : (live ? mem_rdata : hold);
  assign pix_first = pix_valid && (pix_tap == 4'd0);
  assign pix_last  = pix_valid && (pix_tap == LAST_TAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_SCAN;
        S_SCAN:  if (mem_en && last_issue) state <= S_DRAIN;
        // after the final issue only that one pixel is outstanding
        S_DRAIN: if (xfer) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kx  <= '0;
      ky  <= '0;
      col <= '0;
      row <= '0;
    end else if (state == S_IDLE && start) begin
      kx  <= '0;
      ky  <= '0;
      col <= '0;
      row <= '0;
    end else if (mem_en) begin
      if (kx != LAST_K) begin
        kx <= kx + 2'd1;
      end else begin
        kx <= '0;
        if (ky != LAST_K) begin
          ky <= ky + 2'd1;
        end else begin
          ky <= '0;
          if (col != LAST_COL) begin
            col <= col + 5'd1;
          end else begin
            col <= '0;
            // full wrap leaves the counters at 0 for the next scan
            row <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      live      <= 1'b0;
      hold      <= '0;
      pix_tap   <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (mem_en) begin
      pix_valid <= 1'b1;
      live      <= 1'b1;
      pix_tap   <= issue_tap;
      win_row   <= row;
      win_col   <= col;
    end else if (xfer) begin
      pix_valid <= 1'b0;
      live      <= 1'b0;
    end else if (live) begin
      hold <= mem_rdata;
      live <= 1'b0;
    end
  end

endmodule
